// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: segment bit order,
// blank pattern and the hex-to-segment table.
package seg_pkg;

    localparam int DIG_N = 8;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Bit positions inside the {dp,g,f,e,d,c,b,a} segment byte
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Entry n holds segments g..a for hex digit n (leftmost literal is entry 15)
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Where the shadow register reloads from on a given cycle
    typedef enum logic [1:0] {
        SRC_SHADOW  = 2'd0,
        SRC_PENDING = 2'd1,
        SRC_INPUT   = 2'd2
    } shadow_src_e;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to seven-segment (g..a, active-high) decoder.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit hex scan driver with frame-aligned double buffering.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 never).
module seg_scan_driver #(
    parameter int CLK_DIV = 50000,
    parameter int DIG_N   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    output logic [2:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_done
);
    import seg_pkg::*;

    localparam int         PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0] SEL_MAX = 3'(DIG_N - 1);

    // load is a fire-and-forget strobe: no ready, it is always accepted
    // (even with en low) and the last strobe before a frame boundary wins.

    logic [PW-1:0] r_presc;
    logic [2:0]    r_sel;
    logic [7:0]    r_seg;
    logic          r_frame_done;
    logic [31:0]   r_shadow;
    logic [7:0]    r_shadow_dp;
    logic [31:0]   r_pend;
    logic [7:0]    r_pend_dp;
    logic          r_pend_valid;

    logic          w_tick;
    logic          w_boundary;
    logic [2:0]    w_sel_nxt;
    shadow_src_e   w_src;
    logic [31:0]   w_shadow_nxt;
    logic [7:0]    w_shadow_dp_nxt;
    logic [3:0]    w_nib;
    logic [6:0]    w_dec;
    logic          w_blank;
    logic [7:0]    w_seg_nxt;

    assign w_tick     = en && (r_presc == PW'(CLK_DIV - 1));
    assign w_boundary = w_tick && (r_sel == SEL_MAX);
    assign w_sel_nxt  = r_sel + 3'd1;

    // A load coinciding with the boundary tick bypasses pending entirely
    always_comb begin
        w_src = SRC_SHADOW;
        if (w_boundary) begin
            if (load) begin
                w_src = SRC_INPUT;
            end else if (r_pend_valid) begin
                w_src = SRC_PENDING;
            end
        end
    end

    always_comb begin
        w_shadow_nxt    = r_shadow;
        w_shadow_dp_nxt = r_shadow_dp;
        case (w_src)
            SRC_INPUT: begin
                w_shadow_nxt    = data_in;
                w_shadow_dp_nxt = dp_in;
            end
            SRC_PENDING: begin
                w_shadow_nxt    = r_pend;
                w_shadow_dp_nxt = r_pend_dp;
            end
            default: ;
        endcase
    end

    assign w_nib = w_shadow_nxt[{w_sel_nxt, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (w_sel_nxt != 3'd0) && ((w_shadow_nxt >> {w_sel_nxt, 2'b00}) == 32'h0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_seg_nxt              = SEG_BLANK;
        w_seg_nxt[SEG_G:SEG_A] = w_blank ? 7'h00 : w_dec;
        w_seg_nxt[SEG_DP]      = w_shadow_dp_nxt[w_sel_nxt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_sel        <= 3'd0;
            r_seg        <= SEG_BLANK;
            r_frame_done <= 1'b0;
            r_shadow     <= 32'h0;
            r_shadow_dp  <= 8'h00;
            r_pend       <= 32'h0;
            r_pend_dp    <= 8'h00;
            r_pend_valid <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (en) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
            // sel and seg only ever move together, so they always correspond
            if (w_tick) begin
                r_sel <= w_sel_nxt;
                r_seg <= w_seg_nxt;
            end else if (!en) begin
                r_seg <= SEG_BLANK;
            end
            r_shadow    <= w_shadow_nxt;
            r_shadow_dp <= w_shadow_dp_nxt;
            if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end else if (load) begin
                r_pend       <= data_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign sel        = r_sel;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with a frame-level reference model.
module tb_seg_scan_driver;

  localparam int CLK_DIV = 4;
  localparam int W = 44;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [7:0] dp_in = 8'h00;
  logic [2:0] sel;
  logic [7:0] seg;
  logic frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  int m_cnt = 0;
  int m_sel = 0;
  logic [31:0] m_shadow = 32'h0;
  logic [7:0] m_sdp = 8'h00;
  logic [31:0] m_pend = 32'h0;
  logic [7:0] m_pdp = 8'h00;
  bit m_pv = 1'b0;
  logic [7:0] m_seg = 8'h00;
  logic [2:0] prev_sel = 3'd0;

  logic [6:0] dec_tbl [16];

  seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .load(load),
    .data_in(data_in),
    .dp_in(dp_in),
    .sel(sel),
    .seg(seg),
    .frame_done(frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic logic [7:0] ref_seg(input logic [31:0] v, input logic [7:0] dp, input int k);
    logic [31:0] upper;
    logic [6:0] bits;
    upper = v >> (4 * k);
    bits = dec_tbl[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && upper == 32'h0) bits = 7'h00;
`endif
    return {dp[k], bits};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_sel = 0;
    m_shadow = 32'h0;
    m_sdp = 8'h00;
    m_pend = 32'h0;
    m_pdp = 8'h00;
    m_pv = 1'b0;
    m_seg = 8'h00;
    exp_q.delete();
  endtask

  // driver: one clock of stimulus, plus the model's view of that clock
  task automatic drive(input logic e, input logic ld, input logic [31:0] d, input logic [7:0] p);
    bit tk;
    bit bnd;
    @(negedge clk);
    en = e;
    load = ld;
    data_in = d;
    dp_in = p;
    cyc++;
    tk = e && (m_cnt % CLK_DIV == CLK_DIV - 1);
    if (e) m_cnt++;
    bnd = tk && (m_sel == 7);
    if (bnd) begin
      if (ld) begin
        m_shadow = d;
        m_sdp = p;
      end else if (m_pv) begin
        m_shadow = m_pend;
        m_sdp = m_pdp;
      end
      m_pv = 1'b0;
    end else if (ld) begin
      m_pend = d;
      m_pdp = p;
      m_pv = 1'b1;
    end
    if (tk) begin
      m_sel = (m_sel + 1) % 8;
      m_seg = ref_seg(m_shadow, m_sdp, m_sel);
      exp_q.push_back({cyc, 3'(m_sel), m_seg, bnd});
    end else if (!e) begin
      m_seg = 8'h00;
    end
  endtask

  // monitor: a change of sel is a scan step and must match the queue head
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (!rst_n) begin
      prev_sel = sel;
    end else if (sel != prev_sel) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", 64'(sel), 64'(prev_sel));
      end else begin
        e = exp_q.pop_front();
        check("step_cycle", 64'(cyc), 64'(e[43:12]));
        check("step_sel", 64'(sel), 64'(e[11:9]));
        check("step_seg", 64'(seg), 64'(e[8:1]));
        check("step_frame_done", 64'(frame_done), 64'(e[0]));
      end
      prev_sel = sel;
    end else begin
      check("hold_seg", 64'(seg), 64'(m_seg));
      check("idle_frame_done", 64'(frame_done), 64'(1'b0));
    end
  end

  initial begin
    dec_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    #2;
    check("reset_sel", 64'(sel), 64'(0));
    check("reset_seg", 64'(seg), 64'(0));
    check("reset_frame_done", 64'(frame_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // free-running scan of blank value
    repeat (40) drive(1'b1, 1'b0, 32'h0, 8'h00);

    // mid-frame load only shows after the wrap
    drive(1'b1, 1'b1, 32'h89ABCDEF, 8'h01);
    repeat (70) drive(1'b1, 1'b0, 32'h0, 8'h00);

    // back-to-back loads within one frame: last wins
    drive(1'b1, 1'b1, 32'h11111111, 8'h00);
    repeat (3) drive(1'b1, 1'b0, 32'h0, 8'h00);
    drive(1'b1, 1'b1, 32'h22222222, 8'h00);
    repeat (70) drive(1'b1, 1'b0, 32'h0, 8'h00);

    // load on the boundary tick bypasses into digit 0
    while (!((m_cnt % CLK_DIV == CLK_DIV - 1) && m_sel == 7)) drive(1'b1, 1'b0, 32'h0, 8'h00);
    drive(1'b1, 1'b1, 32'h00000007, 8'h00);
    repeat (40) drive(1'b1, 1'b0, 32'h0, 8'h00);

    // enable dropped at sel 3, with a load accepted while disabled
    while (m_sel != 3) drive(1'b1, 1'b0, 32'h0, 8'h00);
    repeat (10) drive(1'b0, 1'b0, 32'h0, 8'h00);
    drive(1'b0, 1'b1, 32'h00000120, 8'h80);
    repeat (9) drive(1'b0, 1'b0, 32'h0, 8'h00);
    repeat (80) drive(1'b1, 1'b0, 32'h0, 8'h00);

    // randomized traffic
    repeat (1500) begin
      logic [31:0] d;
      d = $urandom >> $urandom_range(0, 31);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, d, 8'($urandom_range(0, 255)));
    end

    // asynchronous reset mid-scan drops a pending value
    check("queue_drained_before_reset", 64'(exp_q.size()), 64'(0));
    drive(1'b1, 1'b1, 32'hDEADBEEF, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_sel", 64'(sel), 64'(0));
    check("midreset_seg", 64'(seg), 64'(0));
    check("midreset_frame_done", 64'(frame_done), 64'(0));
    model_reset();
    @(negedge clk);
    en = 1'b0;
    load = 1'b0;
    rst_n = 1'b1;
    repeat (70) drive(1'b1, 1'b0, 32'h0, 8'h00);

    @(negedge clk);
    check("queue_drained_at_end", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Upstream stage of the 8-digit seven-segment display path. It holds a 32-bit value as eight hex nibbles and scans them at 1 kHz. For each position it emits the 3-bit digit index `sel`, which the downstream one-hot digit selector consumes, plus the matching registered 8-bit segment pattern. New display values are double-buffered and take effect only at a frame boundary, so a displayed frame never mixes old and new digits.

Parameters:
CLK_DIV, 50000, system clock cycles per scan step (50 MHz in, 1 kHz out); legal range 2..2^20
DIG_N, 8, digit count; fixed at 8 because `sel` is 3 bits; present for documentation and assertions only

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  scan enable; low freezes scanning and blanks segments
load  input  1  one-cycle strobe; captures data_in and dp_in
data_in  input  32  digit k = data_in[4k+3:4k], digit 0 rightmost
dp_in  input  8  decimal point per digit, bit k belongs to digit k
sel  output  3  current digit index, 0..7
seg  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high
frame_done  output  1  one-cycle pulse when sel wraps 7->0

Behaviour:
- Reset (async assert, sync release): prescaler=0, sel=0, seg=8'h00, frame_done=0, shadow data/dp=0, pending data/dp=0, pending_valid=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en=1.
  - tick=1 in the cycle the count equals CLK_DIV-1; the count returns to 0 on the next edge.
- On a tick:
  - sel <= sel+1, modulo 8.
  - seg <= decode(shadow digit[sel+1]) with dp bit = shadow_dp[sel+1].
  - sel and seg change on the same edge, so they always correspond.
  - Latency from tick to new outputs is one clock.
- First tick after reset moves sel 0->1. seg is blank until that first tick.
- Decode: 0-F → 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (bits g..a; dp added as bit 7).
- load=1: pending <= {data_in, dp_in}, pending_valid <= 1. Back-to-back loads overwrite; the last one wins.
- Frame boundary is a tick with sel==7:
  - frame_done=1 for exactly that cycle (registered, asserted the cycle after the tick edge together with sel=0).
  - If pending_valid: shadow <= pending, pending_valid <= 0. Digit 0 of the new frame already uses the new shadow.
- load in the same cycle as the boundary tick: data_in/dp_in bypass straight into shadow. Pending is cleared, and the new value is used for digit 0.
- en=0:
  - Prescaler and sel hold, and seg <= 8'h00 on the next edge.
  - load is still accepted into pending.
  - When en returns to 1: seg stays blank until the next tick; no restart of the frame.
- Reset asserted mid-frame: all state returns to reset values immediately, and pending data is lost.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: digit k>0 shows seg[6:0]=0 when shadow digits k..7 are all zero. The dp bit is still driven from shadow_dp[k], and digit 0 is never blanked. Example: value 0x00000120 shows "120" on digits 2..0 and digits 7..3 dark.
- Undefined: all eight digits are always decoded, leading zeros included.

Decomposition:
- Shared package `seg_pkg`:
  - 16-entry segment constant table.
  - SEG_BLANK=8'h00.
  - Bit-position constants for the {dp,g..a} order.
  - DIG_N.
- One natural combinational sub-module, `hex7seg_dec` (4-bit in, 7-bit out), instantiated once on the muxed digit.
- Prescaler, sel counter and double buffer stay in the top module.

Test Plan:
All scenarios use CLK_DIV=4.
1. Reset then en=1, no load: sel steps 1,2,..7,0 every 4 clocks; seg=3F each step (dp=0); frame_done pulses once per 32 clocks, coinciding with sel=0.
2. load data_in=32'h89ABCDEF, dp_in=8'h01 mid-frame: current frame is unchanged. After the wrap, sel=0 gives seg=F1 (71|dp), sel=1 gives 79, and sel=7 gives 7F.
3. Two loads (0x11111111 then 0x22222222) within one frame: the next frame shows 5B on every digit, and 0x11111111 is never displayed.
4. load 0x00000007 coinciding with the boundary tick: digit 0 immediately shows 07 in the cycle sel becomes 0.
5. en dropped at sel=3 for 20 clocks: sel holds 3, seg=00 the cycle after; on re-enable sel reaches 4 after exactly 4 clocks.
6. With LEADING_ZERO_BLANK_EN: load 0x00000120, dp_in=8'h80: digits 0..2 show 3F,5B,06; digits 3..6 show 00; digit 7 shows 80. Reset asserted mid-scan: sel=0 and seg=00 asynchronously.
